// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported, variable-latency memory between
// the instruction-fetch port and the data port, with acknowledge timeout.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

    state_t            state, state_nxt;
    port_t             lat_port, last_grant;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  wait_cnt;
    logic              grant_d;
    logic              any_req;
    logic              timeout_hit;
    logic [DATA_W-1:0] ack_data;

    // On a tie the port that did not win last time gets the memory.
    assign any_req     = i_req | d_req;
    assign grant_d     = d_req & (~i_req | (last_grant == PORT_I));
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT));
    assign ack_data    = lat_we ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   if (mem_ack || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            lat_port   <= PORT_I;
            last_grant <= PORT_I;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            wait_cnt   <= '0;
            i_rdata    <= '0;
            i_err      <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        lat_port   <= grant_d ? PORT_D : PORT_I;
                        last_grant <= grant_d ? PORT_D : PORT_I;
                        lat_addr   <= grant_d ? d_addr : i_addr;
                        lat_we     <= grant_d & d_we;
                        lat_wdata  <= grant_d ? d_wdata : '0;
                        wait_cnt   <= CNT_W'(1);
                    end
                end
                ISSUE: begin
                    // An ack in the final allowed cycle still counts as success.
                    if (mem_ack || timeout_hit) begin
                        wait_cnt <= '0;
                        if (lat_port == PORT_D) begin
                            d_rdata <= mem_ack ? ack_data : '0;
                            d_err   <= ~mem_ack;
                        end else begin
                            i_rdata <= mem_ack ? ack_data : '0;
                            i_err   <= ~mem_ack;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (state == ISSUE);
    assign mem_we    = lat_we;
    assign mem_addr  = lat_addr & ~ADDR_W'(3);
    assign mem_wdata = lat_wdata;
    assign i_done    = (state == RESP) && (lat_port == PORT_I);
    assign d_done    = (state == RESP) && (lat_port == PORT_D);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard-driven bench for mem_port_arbiter: per-scenario tasks drive the
// requesters and play the memory, comparing completions against queued results.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_done, i_err, d_done, d_err;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_req, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    int          req_cycles, done_seen, lat;
    logic [31:0] obs_rdata, obs_addr, obs_wdata;
    logic        obs_err, obs_we;
    exp_t        e;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .RESET(RESET),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plays the memory for one transaction: acks in ISSUE cycle ack_at (0 = never)
    // and returns what was seen up to the first done pulse.
    task automatic serve_txn(input int ack_at, input logic [31:0] rd,
                             output int rc, output int ds, output logic [31:0] ordata,
                             output logic oerr, output logic [31:0] oaddr, output logic owe,
                             output logic [31:0] owdata, output int olat);
        rc = 0; ds = 0; ordata = '0; oerr = 1'b0; oaddr = '0; owe = 1'b0; owdata = '0; olat = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            mem_ack = 1'b0;
            if (mem_req) begin
                rc++;
                if (rc == 1) begin
                    oaddr = mem_addr; owe = mem_we; owdata = mem_wdata;
                end
                if (rc == ack_at) begin
                    mem_ack = 1'b1; mem_rdata = rd;
                end
            end
            if (i_done || d_done) begin
                ds     = (d_done ? 2 : 0) + (i_done ? 1 : 0);
                ordata = d_done ? d_rdata : i_rdata;
                oerr   = d_done ? d_err : i_err;
                olat   = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick(); tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, i_done, d_done, i_rdata, d_rdata, i_err, d_err, busy} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got mem_req=%b mem_we=%b mem_addr=%h busy=%b i_done=%b d_done=%b expected all zero",
                     mem_req, mem_we, mem_addr, busy, i_done, d_done);
        end
        RESET = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset got busy=%b mem_req=%b expected 0 0", busy, mem_req);
        end
    endtask

    task automatic test_tie();
        i_req = 1'b1; i_addr = 32'h0000_1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
        sb.push_back('{1'b1, 32'hAAAA_0001, 1'b0});
        serve_txn(1, 32'hAAAA_0001, req_cycles, done_seen, obs_rdata, obs_err, obs_addr, obs_we, obs_wdata, lat);
        e = sb.pop_front();
        checks++;
        if (done_seen != 2 || lat != 2 || obs_addr !== 32'h2000 || obs_rdata !== e.rdata || obs_err !== e.err) begin
            failures++;
            $display("[TB] FAIL tie_first got done=%0d lat=%0d addr=%h rdata=%h err=%b expected done=2 lat=2 addr=00002000 rdata=%h err=%b",
                     done_seen, lat, obs_addr, obs_rdata, obs_err, e.rdata, e.err);
        end
        // Data raises a fresh request at once: second tie, instruction's turn.
        d_addr = 32'h0000_2004;
        sb.push_back('{1'b0, 32'hBBBB_0002, 1'b0});
        serve_txn(1, 32'hBBBB_0002, req_cycles, done_seen, obs_rdata, obs_err, obs_addr, obs_we, obs_wdata, lat);
        e = sb.pop_front();
        checks++;
        if (done_seen != 1 || lat != 3 || obs_addr !== 32'h1000 || obs_rdata !== e.rdata || obs_err !== e.err) begin
            failures++;
            $display("[TB] FAIL tie_second got done=%0d lat=%0d addr=%h rdata=%h err=%b expected done=1 lat=3 addr=00001000 rdata=%h err=%b",
                     done_seen, lat, obs_addr, obs_rdata, obs_err, e.rdata, e.err);
        end
        i_req = 1'b0;
        sb.push_back('{1'b1, 32'hCCCC_0003, 1'b0});
        serve_txn(1, 32'hCCCC_0003, req_cycles, done_seen, obs_rdata, obs_err, obs_addr, obs_we, obs_wdata, lat);
        e = sb.pop_front();
        checks++;
        if (done_seen != 2 || lat != 3 || obs_addr !== 32'h2004 || obs_rdata !== e.rdata || obs_err !== e.err) begin
            failures++;
            $display("[TB] FAIL tie_third got done=%0d lat=%0d addr=%h rdata=%h err=%b expected done=2 lat=3 addr=00002004 rdata=%h err=%b",
                     done_seen, lat, obs_addr, obs_rdata, obs_err, e.rdata, e.err);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        i_req = 1'b1; i_addr = 32'h8000_0003;
        sb.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0});
        serve_txn(1, 32'hDEAD_BEEF, req_cycles, done_seen, obs_rdata, obs_err, obs_addr, obs_we, obs_wdata, lat);
        e = sb.pop_front();
        checks++;
        if (obs_addr !== 32'h8000_0000 || obs_we !== 1'b0 || req_cycles != 1) begin
            failures++;
            $display("[TB] FAIL fetch_mem_side got addr=%h we=%b req_cycles=%0d expected addr=80000000 we=0 req_cycles=1",
                     obs_addr, obs_we, req_cycles);
        end
        checks++;
        if (done_seen != 1 || lat != 2 || obs_rdata !== e.rdata || obs_err !== e.err) begin
            failures++;
            $display("[TB] FAIL fetch_done got done=%0d lat=%0d rdata=%h err=%b expected done=1 lat=2 rdata=%h err=%b",
                     done_seen, lat, obs_rdata, obs_err, e.rdata, e.err);
        end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_data_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'h1234_5678;
        sb.push_back('{1'b1, 32'h0, 1'b0});
        serve_txn(4, 32'hFFFF_FFFF, req_cycles, done_seen, obs_rdata, obs_err, obs_addr, obs_we, obs_wdata, lat);
        e = sb.pop_front();
        checks++;
        if (req_cycles != 4 || obs_we !== 1'b1 || obs_addr !== 32'h100 || obs_wdata !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL write_mem_side got req_cycles=%0d we=%b addr=%h wdata=%h expected 4 1 00000100 12345678",
                     req_cycles, obs_we, obs_addr, obs_wdata);
        end
        checks++;
        if (done_seen != 2 || lat != 5 || obs_rdata !== e.rdata || obs_err !== e.err) begin
            failures++;
            $display("[TB] FAIL write_done got done=%0d lat=%0d rdata=%h err=%b expected done=2 lat=5 rdata=%h err=%b",
                     done_seen, lat, obs_rdata, obs_err, e.rdata, e.err);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        sb.push_back('{1'b1, 32'h0, 1'b1});
        serve_txn(0, 32'h0, req_cycles, done_seen, obs_rdata, obs_err, obs_addr, obs_we, obs_wdata, lat);
        e = sb.pop_front();
        checks++;
        if (req_cycles != 16 || done_seen != 2 || lat != 17 || obs_rdata !== e.rdata || obs_err !== e.err) begin
            failures++;
            $display("[TB] FAIL timeout_abort got req_cycles=%0d done=%0d lat=%0d rdata=%h err=%b expected 16 2 17 %h %b",
                     req_cycles, done_seen, lat, obs_rdata, obs_err, e.rdata, e.err);
        end
        d_req = 1'b0;
        tick();
        d_req = 1'b1;
        sb.push_back('{1'b1, 32'h5A5A_5A5A, 1'b0});
        serve_txn(16, 32'h5A5A_5A5A, req_cycles, done_seen, obs_rdata, obs_err, obs_addr, obs_we, obs_wdata, lat);
        e = sb.pop_front();
        checks++;
        if (req_cycles != 16 || done_seen != 2 || lat != 17 || obs_rdata !== e.rdata || obs_err !== e.err) begin
            failures++;
            $display("[TB] FAIL timeout_last_ack got req_cycles=%0d done=%0d lat=%0d rdata=%h err=%b expected 16 2 17 %h %b",
                     req_cycles, done_seen, lat, obs_rdata, obs_err, e.rdata, e.err);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
        tick(); tick();
        checks++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_issue got mem_req=%b busy=%b expected 1 1", mem_req, busy);
        end
        RESET = 1'b1;
        tick();
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset got mem_req=%b busy=%b i_done=%b d_done=%b expected 0 0 0 0",
                     mem_req, busy, i_done, d_done);
        end
        RESET = 1'b0; d_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_ack = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL late_ack got busy=%b mem_req=%b i_done=%b d_done=%b expected 0 0 0 0",
                     busy, mem_req, i_done, d_done);
        end
    endtask

    task automatic test_stray_back_to_back();
        mem_ack = 1'b1; mem_rdata = 32'h0000_0011;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stray_ack got busy=%b mem_req=%b i_done=%b d_done=%b expected 0 0 0 0",
                     busy, mem_req, i_done, d_done);
        end
        mem_ack = 1'b0;
        tick();
        i_req = 1'b1; i_addr = 32'h0000_0500;
        sb.push_back('{1'b0, 32'h1111_1111, 1'b0});
        serve_txn(1, 32'h1111_1111, req_cycles, done_seen, obs_rdata, obs_err, obs_addr, obs_we, obs_wdata, lat);
        e = sb.pop_front();
        checks++;
        if (done_seen != 1 || lat != 2 || obs_rdata !== e.rdata || obs_err !== e.err) begin
            failures++;
            $display("[TB] FAIL b2b_first got done=%0d lat=%0d rdata=%h err=%b expected 1 2 %h %b",
                     done_seen, lat, obs_rdata, obs_err, e.rdata, e.err);
        end
        // Request stays high through done, so the next IDLE cycle starts a new fetch.
        i_addr = 32'h0000_0504;
        sb.push_back('{1'b0, 32'h2222_2222, 1'b0});
        serve_txn(1, 32'h2222_2222, req_cycles, done_seen, obs_rdata, obs_err, obs_addr, obs_we, obs_wdata, lat);
        e = sb.pop_front();
        checks++;
        if (done_seen != 1 || lat != 3 || req_cycles != 1 || obs_addr !== 32'h504 || obs_rdata !== e.rdata || obs_err !== e.err) begin
            failures++;
            $display("[TB] FAIL b2b_second got done=%0d lat=%0d req_cycles=%0d addr=%h rdata=%h err=%b expected 1 3 1 00000504 %h %b",
                     done_seen, lat, req_cycles, obs_addr, obs_rdata, obs_err, e.rdata, e.err);
        end
        i_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single_fetch();
        test_data_write();
        test_timeout();
        test_reset_mid();
        test_stray_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one unified, variable-latency, single-ported memory between the CPU datapath's instruction-fetch port (IA/ID) and its data port (MA/MWD/MRD). It latches each request and drives the memory handshake. It returns read data with a one-cycle done pulse per requester, and aborts accesses whose acknowledge never arrives. It sits between the datapath and the memory; the control unit stalls the datapath until the relevant done pulse.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, maximum cycles spent waiting for mem_ack before abort (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- RESET  in  1  reset, synchronous, active-high
- i_req  in  1  instruction fetch request; held until i_done
- i_addr  in  ADDR_W  fetch address; stable while i_req high
- i_done  out  1  one-cycle fetch completion pulse
- i_rdata  out  DATA_W  fetched word; valid when i_done=1
- i_err  out  1  fetch timed out; valid when i_done=1
- d_req  in  1  data access request; held until d_done
- d_we  in  1  1=write, 0=read; stable while d_req high
- d_addr  in  ADDR_W  data address; stable while d_req high
- d_wdata  in  DATA_W  write data; stable while d_req high
- d_done  out  1  one-cycle data completion pulse
- d_rdata  out  DATA_W  read data; valid when d_done=1; 0 on writes
- d_err  out  1  data access timed out; valid when d_done=1
- mem_req  out  1  memory request; held until mem_ack or timeout
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word address, bits [1:0] forced to 0
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion; sampled only while mem_req=1
- busy  out  1  1 whenever state ≠ IDLE

## Operation
- Three states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req=1, choose a winner, latch its addr/we/wdata, and go to ISSUE.
  - The instruction port always latches we=0 and wdata=0.
  - With no request, stay in IDLE.
- Arbitration is round-robin.
  - A single requester wins outright.
  - On a tie, the winner is the port not granted last.
  - last_grant updates on every grant and resets to instruction, so data wins the first tie after reset.
- ISSUE:
  - mem_req=1 and mem_addr/mem_we/mem_wdata come from the latched values.
  - A wait counter starts at 1 on entry and increments each cycle.
  - mem_ack=1 in an ISSUE cycle: capture mem_rdata (or 0 on a write), err=0, go to RESP.
  - No ack by the end of ISSUE cycle TIMEOUT: set rdata=0, err=1, go to RESP. An ack arriving in cycle TIMEOUT itself counts as success.
- RESP:
  - Assert the winner's done for exactly one cycle with registered rdata/err; the other port's done stays 0.
  - Requests are ignored; return to IDLE.
- The requester must drop or change req in the cycle after done. A req still high in the following IDLE cycle is a new request.
- mem_ack outside ISSUE is ignored.
- done/rdata/err are driven only from the RESP registers. rdata/err hold their last value otherwise and are meaningful only with done.

## Timing
- Reset (RESET=1 at an edge), from the next cycle:
  - State: IDLE.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_done=0, d_done=0, i_rdata=0, d_rdata=0, i_err=0, d_err=0, busy=0.
  - Internals: last_grant=instruction, wait counter=0.
- RESET during ISSUE or RESP abandons the transaction silently: no done pulse, and a late mem_ack is ignored.
- Minimum latency with a zero-wait memory (ack in the first ISSUE cycle) is 2 cycles:
  - Cycle 0: req sampled in IDLE.
  - Cycle 1: ISSUE, mem_req=1, ack.
  - Cycle 2: RESP, done=1.
- Latency with ack in ISSUE cycle k is k+1 cycles from req sample to done.
- Worst case is TIMEOUT+1 cycles, ending with err=1.
- mem_req is a registered output. It deasserts in the cycle after ack or timeout and never pulses between back-to-back transactions (IDLE sits between).
- The loser of a tie is served in the next transaction. Its request is re-arbitrated in the IDLE cycle following RESP, with a total wait of at most one transaction plus 2 cycles.

## Test plan
- Single fetch:
  - Stimulus: i_req=1, i_addr=0x80000003; memory acks in cycle 1 with 0xDEADBEEF.
  - Response: mem_addr=0x80000000, mem_we=0; i_done in cycle 2 with i_rdata=0xDEADBEEF, i_err=0, d_done=0.
- Data write with 3 wait states:
  - Stimulus: d_req=1, d_we=1, d_addr=0x100, d_wdata=0x12345678.
  - Response: mem_req held 4 cycles with mem_we=1; d_done in cycle 5 with d_rdata=0, d_err=0.
- Tie:
  - Stimulus: i_req and d_req rise together after reset, each held until its done.
  - Response: data is served first; the fetch is granted in the IDLE cycle after d_done; on the next tie, instruction wins.
- Timeout:
  - Stimulus: TIMEOUT=16, memory never acks a d_req read.
  - Response: mem_req high exactly 16 cycles; d_done with d_err=1, d_rdata=0. An ack in cycle 16 instead gives err=0.
- Reset mid-access:
  - Stimulus: RESET asserted during ISSUE, then mem_ack pulses.
  - Response: next cycle mem_req=0, busy=0, no done pulse; the stray ack causes nothing.
- Stray ack and back-to-back:
  - Stimulus: mem_ack pulses while IDLE; i_req is held high through i_done.
  - Response: the ack is ignored; a second fetch issues after one IDLE cycle.
